// File: rtl/alu_display_pkg.sv
// Shared types and helpers for the ALU/display block: opcodes, display select,
// hex-to-7-segment decode (active-low {g,f,e,d,c,b,a}) and the blank pattern.
package alu_display_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLL  = 3'd5,
    OP_SRL  = 3'd6,
    OP_PASS = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    SHOW_RES = 2'd0,
    SHOW_A   = 2'd1,
    SHOW_B   = 2'd2,
    SHOW_OP  = 2'd3
  } show_sel_t;

  localparam logic [6:0] SSEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_to_sseg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_scan.sv
// Multiplexed 7-segment scanner: prescaler, digit counter, leading-zero blanking.
// Segments and anodes are registered together from the next scan position.
module sseg_scan
  import alu_display_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  blank_lz,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     anodes
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [DIGITS-1:0] lz_zero;
  logic [DIGITS-1:0] anodes_d;
  logic [6:0]        seg_d;
  logic [3:0]        nib;
  logic              blank;
  logic              above_zero;

  always_comb begin
    presc_d = presc_q + 1'b1;
    digit_d = digit_q;
    if (presc_q == PW'(REFRESH_DIV - 1)) begin
      presc_d = '0;
      digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end
  end

  // lz_zero[i]: nibble i and every nibble above it are zero
  always_comb begin
    lz_zero    = '0;
    above_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      above_zero = above_zero && (value[4*i +: 4] == 4'h0);
      lz_zero[i] = above_zero;
    end
  end

  // Outputs are computed for the position the counters move to on this edge,
  // so the registered anode and segment pattern always agree.
  always_comb begin
    anodes_d = '1;
    nib      = 4'h0;
    blank    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_d == DW'(i)) begin
        nib         = value[4*i +: 4];
        anodes_d[i] = 1'b0;
        blank       = blank_lz && (i != 0) && lz_zero[i];
      end
    end
    seg_d = blank ? SSEG_BLANK : hex_to_sseg(nib);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      digit_q  <= '0;
      segments <= 7'b1000000;
      anodes   <= ~DIGITS'(1);
    end else begin
      presc_q  <= presc_d;
      digit_q  <= digit_d;
      segments <= seg_d;
      anodes   <= anodes_d;
    end
  end

endmodule

// File: rtl/alu_display_unit.sv
// ALU with operand/opcode/result registers and flags, feeding a scanned
// 7-segment display of any selected register.
module alu_display_unit
  import alu_display_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_A,
  input  logic              load_B,
  input  logic              load_Op,
  input  logic              updateRes,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [1:0]        show_sel,
  input  logic              blank_lz,
  output logic [6:0]        Segments,
  output logic [DIGITS-1:0] Anodes,
  output logic [3:0]        LEDs
);

  localparam int MSB = WIDTH - 1;
  localparam int VW  = 4 * DIGITS;

  logic [WIDTH-1:0] a_q, b_q, res_q;
  alu_op_t          op_q;
  logic [3:0]       leds_q;

  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH-1:0] sel_val;
  logic [VW-1:0]    disp_val;

  assign sum_ext  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_ext = {1'b0, a_q} - {1'b0, b_q};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res = sum_ext[MSB:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a_q[MSB] == b_q[MSB]) && (sum_ext[MSB] != a_q[MSB]);
      end
      OP_SUB: begin
        // the extra bit of the unsigned difference is the borrow
        alu_res = diff_ext[MSB:0];
        alu_c   = diff_ext[WIDTH];
        alu_v   = (a_q[MSB] != b_q[MSB]) && (diff_ext[MSB] != a_q[MSB]);
      end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SLL: begin
        alu_res = {a_q[MSB-1:0], 1'b0};
        alu_c   = a_q[MSB];
      end
      OP_SRL: begin
        alu_res = {1'b0, a_q[MSB:1]};
        alu_c   = a_q[0];
      end
      default: alu_res = b_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_ADD;
      res_q  <= '0;
      leds_q <= '0;
    end else begin
      if (load_A)  a_q  <= data_in;
      if (load_B)  b_q  <= data_in;
      if (load_Op) op_q <= alu_op_t'(data_in[2:0]);
      if (updateRes) begin
        res_q  <= alu_res;
        leds_q <= {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
      end
    end
  end

  assign LEDs = leds_q;

  always_comb begin
    case (show_sel_t'(show_sel))
      SHOW_RES: sel_val = res_q;
      SHOW_A:   sel_val = a_q;
      SHOW_B:   sel_val = b_q;
      default:  sel_val = {{(WIDTH-3){1'b0}}, op_q};
    endcase
  end

  generate
    if (WIDTH >= VW) begin : g_trunc
      assign disp_val = sel_val[VW-1:0];
    end else begin : g_zext
      assign disp_val = {{(VW-WIDTH){1'b0}}, sel_val};
    end
  endgenerate

  sseg_scan #(
    .DIGITS     (DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk     (clk),
    .rst_n   (reset),
    .value   (disp_val),
    .blank_lz(blank_lz),
    .segments(Segments),
    .anodes  (Anodes)
  );

endmodule

// File: tb/tb_alu_display_unit.sv
// Bench: 16-bit and 8-bit instances share stimulus; checked against an arithmetic model.
module tb_alu_display_unit;

  localparam int D = 4;
  localparam int R = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_A = 1'b0, load_B = 1'b0, load_Op = 1'b0, updateRes = 1'b0;
  logic [15:0] data_in = '0;
  logic [1:0]  show_sel = '0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg16, seg8;
  logic [3:0]  an16, an8, leds16, leds8;

  always #5 clk = ~clk;

  alu_display_unit #(.WIDTH(16), .DIGITS(D), .REFRESH_DIV(R)) dut16 (
    .clk(clk), .reset(reset), .load_A(load_A), .load_B(load_B), .load_Op(load_Op),
    .updateRes(updateRes), .data_in(data_in), .show_sel(show_sel), .blank_lz(blank_lz),
    .Segments(seg16), .Anodes(an16), .LEDs(leds16));

  alu_display_unit #(.WIDTH(8), .DIGITS(D), .REFRESH_DIV(R)) dut8 (
    .clk(clk), .reset(reset), .load_A(load_A), .load_B(load_B), .load_Op(load_Op),
    .updateRes(updateRes), .data_in(data_in[7:0]), .show_sel(show_sel), .blank_lz(blank_lz),
    .Segments(seg8), .Anodes(an8), .LEDs(leds8));

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state: index 0 = 16-bit instance, 1 = 8-bit instance
  int         wid [2] = '{16, 8};
  longint     m_a [2], m_b [2], m_res [2];
  logic [3:0] m_leds [2];
  int         m_op;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void alu_ref(input int w, input longint a, input longint b, input int op,
                                  output longint res, output logic [3:0] leds);
    longint mask, half, sa, sb, sr;
    logic   c, v;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    sa = (a >= half) ? a - (mask + 1) : a;
    sb = (b >= half) ? b - (mask + 1) : b;
    c = 1'b0;
    v = 1'b0;
    sr = 0;
    case (op)
      0: begin res = (a + b) & mask; c = (a + b) > mask; sr = sa + sb; v = (sr >= half) || (sr < -half); end
      1: begin res = (a - b) & mask; c = (a < b);        sr = sa - sb; v = (sr >= half) || (sr < -half); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = (a * 2) & mask; c = (a >= half); end
      6: begin res = a / 2; c = (a % 2) == 1; end
      default: res = b;
    endcase
    leds = {res >= half, res == 0, c, v};
  endfunction

  function automatic longint disp_val(input int k);
    case (show_sel)
      2'd0: return m_res[k];
      2'd1: return m_a[k];
      2'd2: return m_b[k];
      default: return longint'(m_op);
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input longint v, input int i, input logic bl);
    longint above;
    above = v >> (4 * i);
    if (bl && i > 0 && above == 0) return 7'h7F;
    return hex_tab[above & 15];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_a[k] = 0; m_b[k] = 0; m_res[k] = 0; m_leds[k] = 4'h0;
    end
    m_op = 0;
  endtask

  task automatic drive(input logic la, input logic lb, input logic lo, input logic upd,
                       input logic [15:0] d);
    longint r;
    logic [3:0] l;
    @(negedge clk);
    load_A = la; load_B = lb; load_Op = lo; updateRes = upd; data_in = d;
    for (int k = 0; k < 2; k++) begin
      if (upd) begin
        alu_ref(wid[k], m_a[k], m_b[k], m_op, r, l);
        m_res[k] = r;
        m_leds[k] = l;
      end
      if (la) m_a[k] = longint'(d) & ((longint'(1) << wid[k]) - 1);
      if (lb) m_b[k] = longint'(d) & ((longint'(1) << wid[k]) - 1);
    end
    if (lo) m_op = int'(d[2:0]);
    @(negedge clk);
    load_A = 0; load_B = 0; load_Op = 0; updateRes = 0;
    chk("leds16", 32'(leds16), 32'(m_leds[0]));
    chk("leds8", 32'(leds8), 32'(m_leds[1]));
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    drive(1, 0, 0, 0, a);
    drive(0, 1, 0, 0, b);
    drive(0, 0, 1, 0, {13'd0, op});
    drive(0, 0, 0, 1, 16'h0);
  endtask

  // Align to the start of digit 0, then watch one full frame on both instances.
  task automatic check_frame(input string tag);
    logic [3:0] prev;
    int         got_sync, bad_one, unstable;
    int         cnt [4];
    logic [6:0] s16 [4], s8 [4];
    got_sync = 0; bad_one = 0; unstable = 0;
    cnt = '{default: 0};
    prev = an16;
    for (int c = 0; c < 3 * D * R && got_sync == 0; c++) begin
      @(negedge clk);
      if (an16[0] == 1'b0 && prev[0] == 1'b1) got_sync = 1;
      else prev = an16;
    end
    chk($sformatf("%s:sync", tag), 32'(got_sync), 32'd1);
    if (got_sync != 0) begin
      for (int c = 0; c < D * R; c++) begin
        if (c > 0) @(negedge clk);
        if ($countones(~an16) != 1 || an8 !== an16) bad_one++;
        else begin
          for (int i = 0; i < D; i++) begin
            if (an16[i] == 1'b0) begin
              if (cnt[i] == 0) begin s16[i] = seg16; s8[i] = seg8; end
              else if (s16[i] !== seg16 || s8[i] !== seg8) unstable++;
              cnt[i]++;
            end
          end
        end
      end
      chk($sformatf("%s:one_anode", tag), 32'(bad_one), 32'd0);
      chk($sformatf("%s:stable", tag), 32'(unstable), 32'd0);
      for (int i = 0; i < D; i++) begin
        chk($sformatf("%s:dwell[%0d]", tag, i), 32'(cnt[i]), 32'(R));
        chk($sformatf("%s:seg16[%0d]", tag, i), 32'(s16[i]), 32'(exp_seg(disp_val(0), i, blank_lz)));
        chk($sformatf("%s:seg8[%0d]", tag, i), 32'(s8[i]), 32'(exp_seg(disp_val(1), i, blank_lz)));
      end
    end
  endtask

  initial begin
    int found, cnt;
    logic [15:0] d;
    model_reset();
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_anodes", 32'(an16), 32'h0000_000E);
    chk("rst_segments", 32'(seg16), 32'h0000_0040);
    chk("rst_leds", 32'(leds16), 32'h0);
    reset = 1'b1;
    check_frame("rst");

    do_op(16'h7FFF, 16'h0001, 3'd0);
    chk("add_ovf_leds", 32'(leds16), 32'h9);
    chk("add_ovf_res", 32'(m_res[0]), 32'h8000);
    check_frame("add_ovf");

    do_op(16'h0003, 16'h0005, 3'd1);
    chk("sub_borrow_leds", 32'(leds16), 32'hA);
    check_frame("sub_borrow");
    do_op(16'h1234, 16'h1234, 3'd1);
    chk("sub_zero_leds", 32'(leds16), 32'h4);

    do_op(16'h0001, 16'h0001, 3'd0);
    drive(1, 0, 0, 1, 16'h0010);
    chk("samecyc_res", 32'(m_res[0]), 32'h2);
    show_sel = 2'd0;
    check_frame("samecyc_res");
    show_sel = 2'd1;
    check_frame("samecyc_a");

    drive(1, 0, 0, 0, 16'h00A5);
    show_sel = 2'd1;
    blank_lz = 1'b1;
    check_frame("blank_a5");

    drive(0, 1, 0, 0, 16'h00C3);
    drive(0, 0, 1, 0, 16'h0007);
    drive(0, 0, 0, 1, 16'h0000);
    show_sel = 2'd0;
    blank_lz = 1'b0;
    check_frame("pass_b");

    for (int it = 0; it < 30; it++) begin
      d = 16'($urandom);
      if (it % 7 == 0) d = 16'h0000;
      if (it % 7 == 1) d = 16'hFFFF;
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), d);
      drive(0, 0, 0, 1, 16'h0);
      show_sel = 2'($urandom);
      blank_lz = 1'($urandom);
      check_frame($sformatf("rnd%0d", it));
    end

    found = 0;
    for (int c = 0; c < 3 * D * R && found == 0; c++) begin
      @(negedge clk);
      if (an16 == 4'b1011) found = 1;
    end
    chk("mid_scan_reach_d2", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    chk("async_anodes", 32'(an16), 32'h0000_000E);
    chk("async_segments", 32'(seg16), 32'h0000_0040);
    chk("async_leds", 32'(leds16), 32'h0);
    @(negedge clk);
    chk("held_leds8", 32'(leds8), 32'h0);
    reset = 1'b1;
    cnt = 0;
    for (int c = 0; c < 4 * R && an16 == 4'b1110; c++) begin
      cnt++;
      @(negedge clk);
    end
    chk("restart_d0_dwell", 32'(cnt), 32'(R));
    chk("restart_d1", 32'(an16), 32'h0000_000D);
    show_sel = 2'd1;
    check_frame("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
